laser_sched: RTL

- Front-end controller that shares one LASER two-circle coverage engine between two point-stream requesters.
- Arbitrates per frame, then buffers one 40-point frame from the granted requester, because requester streams may stall and the engine does not.
- Resets the engine, replays the frame on 40 consecutive cycles, waits for the engine's DONE pulse and returns the circle centres tagged with the requester ID.
- A watchdog reports a hung engine as a timeout result.

---
 rtl/laser_sched.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/laser_sched.sv
// laser_sched: shares one LASER two-circle coverage engine between two
// point-stream requesters. Arbitrates per frame, buffers one frame, replays it
// to the engine on consecutive cycles, and returns the engine's circle centres
// (or a watchdog timeout result) tagged with the owning requester.
module laser_sched #(
  parameter int NUM_PTS = 40,
  parameter int TIMEOUT = 100000,
  parameter int TO_W    = 17
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       S0_VALID,
  output logic       S0_READY,
  input  logic [3:0] S0_X,
  input  logic [3:0] S0_Y,
  input  logic       S1_VALID,
  output logic       S1_READY,
  input  logic [3:0] S1_X,
  input  logic [3:0] S1_Y,
  output logic       ENG_RST,
  output logic [3:0] ENG_X,
  output logic [3:0] ENG_Y,
  input  logic [3:0] ENG_C1X,
  input  logic [3:0] ENG_C1Y,
  input  logic [3:0] ENG_C2X,
  input  logic [3:0] ENG_C2Y,
  input  logic       ENG_DONE,
  output logic       R_VALID,
  input  logic       R_READY,
  output logic       R_ID,
  output logic [3:0] R_C1X,
  output logic [3:0] R_C1Y,
  output logic [3:0] R_C2X,
  output logic [3:0] R_C2Y,
  output logic       R_TIMEOUT,
  output logic       BUSY
);

  localparam int CNT_W = $clog2(NUM_PTS);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NUM_PTS - 1);
  localparam logic [TO_W-1:0]  WDOG_ZERO = {TO_W{1'b0}};
  localparam logic [TO_W-1:0]  WDOG_ONE  = TO_W'(1);
  localparam logic [TO_W-1:0]  WDOG_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_STREAM = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESULT = 3'd4
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [TO_W-1:0]  wdog_r;
  logic             grant_r;
  logic             last_r;     // requester granted most recently (1 after reset so S0 wins first)
  logic             arb_s;
  logic             beat_s;
  logic             last_pt_s;
  logic             wdog_exp_s;
  logic [7:0]       buf_r [NUM_PTS];
  logic [3:0]       sel_x_s;
  logic [3:0]       sel_y_s;

  logic             eng_rst_r;
  logic             r_valid_r;
  logic             r_id_r;
  logic [3:0]       r_c1x_r;
  logic [3:0]       r_c1y_r;
  logic [3:0]       r_c2x_r;
  logic [3:0]       r_c2y_r;
  logic             r_timeout_r;

  assign sel_x_s    = grant_r ? S1_X : S0_X;
  assign sel_y_s    = grant_r ? S1_Y : S0_Y;
  assign beat_s     = (state_r == ST_FILL) && (grant_r ? S1_VALID : S0_VALID);
  assign last_pt_s  = (cnt_r == CNT_LAST);
  assign wdog_exp_s = (wdog_r == WDOG_LAST);

  assign S0_READY  = (state_r == ST_FILL) && !grant_r;
  assign S1_READY  = (state_r == ST_FILL) && grant_r;
  assign BUSY      = (state_r != ST_IDLE);
  assign ENG_RST   = eng_rst_r;
  assign ENG_X     = (state_r == ST_STREAM) ? buf_r[cnt_r][3:0] : 4'd0;
  assign ENG_Y     = (state_r == ST_STREAM) ? buf_r[cnt_r][7:4] : 4'd0;
  assign R_VALID   = r_valid_r;
  assign R_ID      = r_id_r;
  assign R_C1X     = r_c1x_r;
  assign R_C1Y     = r_c1y_r;
  assign R_C2X     = r_c2x_r;
  assign R_C2Y     = r_c2y_r;
  assign R_TIMEOUT = r_timeout_r;

  // Round-robin arbitration and next-state decode.
  always_comb begin
    state_s = state_r;
    arb_s   = grant_r;
    if (S0_VALID && S1_VALID) begin
      arb_s = ~last_r;
    end else if (S1_VALID) begin
      arb_s = 1'b1;
    end else begin
      arb_s = 1'b0;
    end
    case (state_r)
      ST_IDLE: begin
        if (S0_VALID || S1_VALID) state_s = ST_FILL;
        else                      state_s = ST_IDLE;
      end
      ST_FILL: begin
        if (beat_s && last_pt_s) state_s = ST_STREAM;
        else                     state_s = ST_FILL;
      end
      ST_STREAM: begin
        if (last_pt_s) state_s = ST_WAIT;
        else           state_s = ST_STREAM;
      end
      ST_WAIT: begin
        if (ENG_DONE || wdog_exp_s) state_s = ST_RESULT;
        else                        state_s = ST_WAIT;
      end
      ST_RESULT: begin
        if (R_READY) state_s = ST_IDLE;
        else         state_s = ST_RESULT;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, counters, grant, engine reset and result registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      wdog_r      <= WDOG_ZERO;
      grant_r     <= 1'b0;
      last_r      <= 1'b1;
      eng_rst_r   <= 1'b1;
      r_valid_r   <= 1'b0;
      r_id_r      <= 1'b0;
      r_c1x_r     <= 4'd0;
      r_c1y_r     <= 4'd0;
      r_c2x_r     <= 4'd0;
      r_c2y_r     <= 4'd0;
      r_timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      eng_rst_r <= !((state_s == ST_STREAM) || (state_s == ST_WAIT));
      case (state_r)
        ST_IDLE: begin
          cnt_r <= CNT_ZERO;
          if (S0_VALID || S1_VALID) grant_r <= arb_s;
        end
        ST_FILL: begin
          if (beat_s) begin
            if (last_pt_s) cnt_r <= CNT_ZERO;
            else           cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_STREAM: begin
          if (last_pt_s) begin
            cnt_r  <= CNT_ZERO;
            wdog_r <= WDOG_ZERO;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_WAIT: begin
          wdog_r <= wdog_r + WDOG_ONE;
          // A DONE on the expiry cycle still counts as a real result.
          if (ENG_DONE) begin
            r_valid_r   <= 1'b1;
            r_id_r      <= grant_r;
            r_c1x_r     <= ENG_C1X;
            r_c1y_r     <= ENG_C1Y;
            r_c2x_r     <= ENG_C2X;
            r_c2y_r     <= ENG_C2Y;
            r_timeout_r <= 1'b0;
          end else if (wdog_exp_s) begin
            r_valid_r   <= 1'b1;
            r_id_r      <= grant_r;
            r_c1x_r     <= 4'd0;
            r_c1y_r     <= 4'd0;
            r_c2x_r     <= 4'd0;
            r_c2y_r     <= 4'd0;
            r_timeout_r <= 1'b1;
          end
        end
        ST_RESULT: begin
          if (R_READY) begin
            r_valid_r <= 1'b0;
            last_r    <= grant_r;
          end
        end
        default: ;
      endcase
    end
  end

  // Frame buffer; contents are don't-care after reset so it carries no reset.
  always_ff @(posedge CLK) begin
    if (beat_s) buf_r[cnt_r] <= {sel_y_s, sel_x_s};
  end

endmodule
